// File: rtl/codec_sample_feeder.sv
// codec_sample_feeder: buffers stereo PCM pairs and presents one pair to the codec per frame.
// Codec inputs change only in the cycle where the rising edge of pcm_accept makes the codec latch them.
module codec_sample_feeder #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter bit HOLD_ON_UNDERRUN = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic                     pcm_accept,
  output logic [WIDTH-1:0]         pcm_left,
  output logic [WIDTH-1:0]         pcm_right,
  output logic                     underrun,
  output logic [15:0]              underrun_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [2*WIDTH-1:0] held, nxt;
  logic accept_q, frame_pulse, empty, full, push, pop;
  assign level = wptr - rptr;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign in_ready = ~full;
  assign push = in_valid & in_ready;
  assign frame_pulse = pcm_accept & ~accept_q;
  assign pop = frame_pulse & enable & ~empty;
  assign underrun = frame_pulse & enable & empty;
  // nxt does not depend on pcm_accept, leaving a single mux on the accept-to-codec path
  always_comb nxt = !enable ? '0 : !empty ? mem[rptr[AW-1:0]] : HOLD_ON_UNDERRUN ? held : '0;
  assign {pcm_left, pcm_right} = frame_pulse ? nxt : held;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      held <= '0;
      accept_q <= 1'b1;
      underrun_count <= '0;
    end else begin
      accept_q <= pcm_accept;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (frame_pulse) held <= nxt;
      if (underrun && !(&underrun_count)) underrun_count <= underrun_count + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= {in_left, in_right};
endmodule

// File: doc/codec_sample_feeder.md
# codec_sample_feeder

Buffers stereo PCM samples from an upstream sample producer (the note/voice player) and hands exactly one sample pair to the AC97 codec interface per codec frame. It watches the codec's playback-accept strobe and changes the codec inputs only at the single clock edge where the codec latches them. Frames with no data available are handled and counted as underruns. Sits between the music datapath and the codec interface, one instance per design.

## Interface
- WIDTH, 18: bits per channel sample (matches codec PCM width).
- DEPTH, 4: FIFO depth in stereo pairs; power of two, ≥2.
- HOLD_ON_UNDERRUN, 0: 0 = output zero on underrun; 1 = repeat last sample.
- clk  in  1  system clock (same clock as the codec interface).
- reset_n  in  1  asynchronous, active-low reset.
- in_left  in  WIDTH  left sample from producer.
- in_right  in  WIDTH  right sample from producer.
- in_valid  in  1  producer has a sample pair.
- in_ready  out  1  feeder can take a pair; transfer when in_valid & in_ready at clk edge.
- enable  in  1  playback enable; low = mute frames, no pops.
- pcm_accept  in  1  codec playback-accept level.
- pcm_left  out  WIDTH  left sample to codec.
- pcm_right  out  WIDTH  right sample to codec.
- underrun  out  1  one-cycle pulse on an underrun frame.
- underrun_count  out  16  saturating underrun counter.
- level  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- frame_pulse = pcm_accept & ~accept_q; accept_q is a register of pcm_accept, reset value 1 (no spurious frame if accept is already high when reset releases).
- FIFO: DEPTH entries of {left,right}, binary read/write pointers one bit wider than index; level = wptr − rptr; full when level == DEPTH, empty when level == 0.
- in_ready = ~full (not dependent on same-cycle pop). Push on in_valid & in_ready.
- On frame_pulse:
  - enable=1, FIFO non-empty: next = FIFO head; pop.
  - enable=1, FIFO empty: underrun. next = 0 (HOLD_ON_UNDERRUN=0) or held (=1); underrun pulses high this cycle; underrun_count += 1, saturating at 16'hFFFF.
  - enable=0: next = 0; no pop; no underrun.
- Output path: pcm_{left,right} = frame_pulse ? next : held; held loads next on frame_pulse edge. This makes the codec latch next at the frame edge and see an unchanged value on every other edge.
- Simultaneous push and pop: both occur; level unchanged. Push into empty FIFO on a frame_pulse cycle: pop sees empty → underrun; pushed pair stays for next frame.
- Reset (any time, including mid-frame): FIFO emptied, held = 0, underrun_count = 0, accept_q = 1, buffered data discarded.

## Timing
- Reset values: pcm_left = pcm_right = 0, in_ready = 1, underrun = 0, underrun_count = 0, level = 0.
- Input-to-codec latency: a pair pushed at edge N is eligible for any frame_pulse at edge ≥ N+1.
- pcm_* change only combinationally within the frame_pulse cycle; stable across every non-frame edge.
- level, in_ready, underrun_count update on the edge after the event; underrun is combinational with frame_pulse.
- One pop maximum per frame; frame period set by the codec (32 clk in simulation).
- Critical path: pcm_accept → mux → pcm_*; keep to one 2:1 mux level.

## Test plan
- Reset with pcm_accept high, release: no frame pulse that cycle, pcm_* = 0, in_ready = 1, level = 0.
- Push (18'h00123, 18'h3FEDC), enable=1, run one frame: at accept rise pcm_left = 18'h00123, pcm_right = 18'h3FEDC, held for the full 32-cycle frame; codec model reports no "changing inputs" error.
- Push 5 pairs with DEPTH=4: in_ready drops after 4th, 5th held off; after one frame in_ready=1 and 5th accepted; frames output pairs 1..5 in order.
- Empty FIFO, enable=1, 3 frames: underrun pulses 3 times, underrun_count = 3, pcm_* = 0 (HOLD=0) or last sample (HOLD=1).
- enable=0 with 2 pairs buffered, 2 frames: pcm_* = 0, level stays 2, underrun_count unchanged; re-enable → pairs emerge in order.
- Push on exact frame_pulse cycle with empty FIFO: underrun counted, pair appears on following frame; force underrun_count to 16'hFFFF then underrun → stays 16'hFFFF.
